// File: rtl/mem_access_pkg.sv
// Shared constants and types for the MEM pipeline stage.
// Optional feature macro: MEM_TIMEOUT_EN (bus request timeout and mem_err_o).
package mem_access_pkg;

  localparam int unsigned MEM_DATA_W     = 16;
  localparam int unsigned MEM_ADDR_W     = 16;
  localparam int unsigned MEM_REG_ADDR_W = 4;
  localparam int unsigned MEM_TIMEOUT    = 15;
  localparam int unsigned MEM_CNT_W      = 4;
  localparam int unsigned MEM_STALL_W    = 6;
  localparam int unsigned MEM_STALL_BIT  = 4;
  localparam int unsigned MEM_OP_W       = 2;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam logic [MEM_DATA_W-1:0] ZERO_WORD    = MEM_DATA_W'(0);
  localparam logic [MEM_DATA_W-1:0] MEM_ERR_DATA = MEM_DATA_W'(16'hFFFF);

  typedef logic [MEM_DATA_W-1:0]     reg_bus_t;
  typedef logic [MEM_ADDR_W-1:0]     addr_bus_t;
  typedef logic [MEM_REG_ADDR_W-1:0] reg_addr_bus_t;
  typedef logic [MEM_STALL_W-1:0]    stall_reg_bus_t;
  typedef logic [MEM_OP_W-1:0]       mem_op_bus_t;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NONE  = 2'b00,
    MEM_OP_LOAD  = 2'b01,
    MEM_OP_STORE = 2'b10,
    MEM_OP_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Request payload held stable on the SRAM bus for the whole REQ phase
  typedef struct packed {
    logic      we;
    addr_bus_t addr;
    reg_bus_t  wdata;
  } mem_bus_req_t;

  // Reserved encoding behaves like "no memory access"
  function automatic logic is_mem_op(input mem_op_bus_t op);
    return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
  endfunction

  function automatic logic is_store_op(input mem_op_bus_t op);
    return op == MEM_OP_STORE;
  endfunction

endpackage

// File: rtl/mem_access_bus_fsm.sv
// Bus transaction sequencer for the MEM stage: state, request latches,
// captured load data and (with MEM_TIMEOUT_EN) the REQ timeout counter.
module mem_bus_fsm
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_hold,
  input  mem_op_bus_t  mem_op,
  input  addr_bus_t    mem_addr,
  input  reg_bus_t     mem_wdata,
  input  reg_bus_t     bus_rdata,
  input  logic         bus_ack,
  output mem_state_e   state,
  output mem_bus_req_t bus_lat,
  output reg_bus_t     load_data
`ifdef MEM_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  mem_state_e   state_d;
  mem_bus_req_t bus_lat_d;
  reg_bus_t     load_data_d;

`ifdef MEM_TIMEOUT_EN
  logic [MEM_CNT_W-1:0] req_cnt;
  logic [MEM_CNT_W-1:0] req_cnt_d;
  logic                 timeout_err_d;
  logic                 req_limit;

  // Last REQ cycle allowed before giving up on the bus
  assign req_limit = (req_cnt == MEM_CNT_W'(TIMEOUT - 1));
`else
  logic unused_cfg;

  assign unused_cfg = ^{MEM_CNT_W'(TIMEOUT), MEM_ERR_DATA};
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= MEM_IDLE;
      bus_lat   <= '0;
      load_data <= ZERO_WORD;
`ifdef MEM_TIMEOUT_EN
      req_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      bus_lat   <= bus_lat_d;
      load_data <= load_data_d;
`ifdef MEM_TIMEOUT_EN
      req_cnt     <= req_cnt_d;
      timeout_err <= timeout_err_d;
`endif
    end
  end

  // Next-state and next-latch logic
  always_comb begin
    state_d     = state;
    bus_lat_d   = bus_lat;
    load_data_d = load_data;
`ifdef MEM_TIMEOUT_EN
    req_cnt_d     = req_cnt;
    timeout_err_d = timeout_err;
`endif
    case (state)
      MEM_IDLE: begin
`ifdef MEM_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
        // Upstream stall does not gate the start; inputs are held upstream
        if (is_mem_op(mem_op)) begin
          bus_lat_d.we    = is_store_op(mem_op);
          bus_lat_d.addr  = mem_addr;
          bus_lat_d.wdata = mem_wdata;
          state_d         = MEM_REQ;
`ifdef MEM_TIMEOUT_EN
          req_cnt_d = '0;
`endif
        end
      end
      MEM_REQ: begin
        if (bus_ack) begin
          if (!bus_lat.we) begin
            load_data_d = bus_rdata;
          end
          state_d = MEM_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (req_limit) begin
          load_data_d   = MEM_ERR_DATA;
          timeout_err_d = 1'b1;
          state_d       = MEM_DONE;
        end else begin
          req_cnt_d = req_cnt + MEM_CNT_W'(1);
        end
`endif
      end
      MEM_DONE: begin
        // Held results stay on the outputs until the MEM stage is released
        if (mem_hold == NO_STOP) begin
          state_d = MEM_IDLE;
`ifdef MEM_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through and runs LW/SW on the
// shared SRAM bus, stalling the pipeline until the write-back triple is ready.
// Optional feature macro: MEM_TIMEOUT_EN (adds mem_err_o and REQ timeout).
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned REG_ADDR_W = MEM_REG_ADDR_W,
  parameter int unsigned TIMEOUT    = MEM_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MEM_STALL_W-1:0] stall,
  input  logic [DATA_W-1:0]      wData_i,
  input  logic                   wReg_i,
  input  logic [REG_ADDR_W-1:0]  wRegAddr_i,
  input  logic [MEM_OP_W-1:0]    memOp_i,
  input  logic [ADDR_W-1:0]      memAddr_i,
  input  logic [DATA_W-1:0]      memData_i,
  output logic [DATA_W-1:0]      wData_o,
  output logic                   wReg_o,
  output logic [REG_ADDR_W-1:0]  wRegAddr_o,
  output logic                   stallreq_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [ADDR_W-1:0]      bus_addr_o,
  output logic [DATA_W-1:0]      bus_wdata_o,
  input  logic [DATA_W-1:0]      bus_rdata_i,
  input  logic                   bus_ack_i
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                   mem_err_o
`endif
);

  mem_state_e   fsm_state;
  mem_bus_req_t bus_lat;
  reg_bus_t     load_data;
  logic         mem_hold;
  logic         unused_stall;

  // Only the MEM-stage hold bit of the stall vector matters here
  assign mem_hold     = stall[MEM_STALL_BIT];
  assign unused_stall = ^{stall[MEM_STALL_W-1:MEM_STALL_BIT+1], stall[MEM_STALL_BIT-1:0]};

`ifdef MEM_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_bus_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_hold    (mem_hold),
    .mem_op      (memOp_i),
    .mem_addr    (MEM_ADDR_W'(memAddr_i)),
    .mem_wdata   (MEM_DATA_W'(memData_i)),
    .bus_rdata   (MEM_DATA_W'(bus_rdata_i)),
    .bus_ack     (bus_ack_i),
    .state       (fsm_state),
    .bus_lat     (bus_lat),
    .load_data   (load_data)
`ifdef MEM_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

`ifdef MEM_TIMEOUT_EN
  // Error flag is only meaningful while the aborted result is presented
  assign mem_err_o = timeout_err && (fsm_state == MEM_DONE);
`endif

  // Output mux: pass-through by default, stall while the bus is busy
  always_comb begin
    wData_o     = wData_i;
    wReg_o      = wReg_i;
    wRegAddr_o  = wRegAddr_i;
    stallreq_o  = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    case (fsm_state)
      MEM_IDLE: begin
        if (is_mem_op(memOp_i)) begin
          stallreq_o = 1'b1;
          wReg_o     = 1'b0;
        end
      end
      MEM_REQ: begin
        stallreq_o  = 1'b1;
        wReg_o      = 1'b0;
        bus_req_o   = 1'b1;
        bus_we_o    = bus_lat.we;
        bus_addr_o  = ADDR_W'(bus_lat.addr);
        bus_wdata_o = DATA_W'(bus_lat.wdata);
      end
      MEM_DONE: begin
        if (!bus_lat.we) begin
          wData_o = DATA_W'(load_data);
        end
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized
// instruction streams against a transaction-level timeline and memory model.
// Optional feature macro: MEM_TIMEOUT_EN (timeout cases and mem_err_o checks).
module tb_mem_access;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [15:0] wData_i;
  logic        wReg_i;
  logic [3:0]  wRegAddr_i;
  logic [1:0]  memOp_i;
  logic [15:0] memAddr_i;
  logic [15:0] memData_i;
  logic [15:0] wData_o;
  logic        wReg_o;
  logic [3:0]  wRegAddr_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [15:0] bus_addr_o;
  logic [15:0] bus_wdata_o;
  logic [15:0] bus_rdata_i;
  logic        bus_ack_i;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err_o;
  logic        e_err_g;
`endif

  int n_chk;
  int n_bad;
  int stall_seen;

  // Memory behind the bus decodes the low three address bits
  logic [15:0] mem_model [8];

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .wData_i     (wData_i),
    .wReg_i      (wReg_i),
    .wRegAddr_i  (wRegAddr_i),
    .memOp_i     (memOp_i),
    .memAddr_i   (memAddr_i),
    .memData_i   (memData_i),
    .wData_o     (wData_o),
    .wReg_o      (wReg_o),
    .wRegAddr_o  (wRegAddr_o),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_err_o   (mem_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then advance past the edge
  task automatic chk_cycle(input string ph, input logic e_stall, input logic e_wreg,
                           input logic chk_wb, input logic [15:0] e_wdata,
                           input logic e_breq, input logic e_bwe,
                           input logic [15:0] e_baddr, input logic [15:0] e_bwdata);
    @(negedge clk);
    if (stallreq_o === 1'b1) stall_seen++;
    chk({ph, ".stallreq"}, 32'(stallreq_o), 32'(e_stall));
    chk({ph, ".wreg"}, 32'(wReg_o), 32'(e_wreg));
    if (chk_wb) begin
      chk({ph, ".wdata"}, 32'(wData_o), 32'(e_wdata));
      chk({ph, ".wregaddr"}, 32'(wRegAddr_o), 32'(wRegAddr_i));
    end
    chk({ph, ".bus_req"}, 32'(bus_req_o), 32'(e_breq));
    chk({ph, ".bus_we"}, 32'(bus_we_o), 32'(e_bwe));
    chk({ph, ".bus_addr"}, 32'(bus_addr_o), 32'(e_baddr));
    chk({ph, ".bus_wdata"}, 32'(bus_wdata_o), 32'(e_bwdata));
`ifdef MEM_TIMEOUT_EN
    chk({ph, ".mem_err"}, 32'(mem_err_o), 32'(e_err_g));
`endif
    @(posedge clk);
    #1;
  endtask

  // Non-memory instruction: one cycle, results pass straight through
  task automatic run_alu(input logic [1:0] op, input logic [15:0] wd,
                         input logic wr, input logic [3:0] wra);
    memOp_i     = op;
    memAddr_i   = 16'($urandom);
    memData_i   = 16'($urandom);
    wData_i     = wd;
    wReg_i      = wr;
    wRegAddr_i  = wra;
    stall       = 6'($urandom);
    bus_ack_i   = 1'($urandom);
    bus_rdata_i = 16'($urandom);
    chk_cycle("alu", 1'b0, wr, 1'b1, wd, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Memory instruction: one IDLE cycle, d+1 REQ cycles (ack in the last),
  // then h held DONE cycles plus the releasing DONE cycle
  task automatic run_mem(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] sdata, input logic [15:0] wd,
                         input logic wr, input logic [3:0] wra,
                         input int d, input int h);
    logic        is_st;
    logic [2:0]  idx;
    logic [15:0] exp_wb;
    is_st       = (op == OP_STORE);
    idx         = addr[2:0];
    memOp_i     = op;
    memAddr_i   = addr;
    memData_i   = sdata;
    wData_i     = wd;
    wReg_i      = wr;
    wRegAddr_i  = wra;
    stall       = 6'($urandom);
    bus_ack_i   = 1'($urandom);
    bus_rdata_i = 16'($urandom);
    stall_seen  = 0;
    chk_cycle("mem_idle", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int r = 0; r <= d; r++) begin
      stall       = 6'($urandom);
      bus_ack_i   = (r == d);
      bus_rdata_i = (r == d && !is_st) ? mem_model[idx] : 16'($urandom);
      chk_cycle("mem_req", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, is_st, addr, sdata);
    end
    if (is_st) begin
      mem_model[idx] = sdata;
      exp_wb = wd;
    end else begin
      exp_wb = mem_model[idx];
    end
    for (int k = 0; k <= h; k++) begin
      stall       = 6'($urandom);
      stall[4]    = (k < h);
      bus_ack_i   = 1'($urandom);
      bus_rdata_i = 16'($urandom);
      chk_cycle("mem_done", 1'b0, wr, 1'b1, exp_wb, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    chk("mem_stall_cycles", 32'(stall_seen), 32'(d + 2));
  endtask

  initial begin
    n_chk       = 0;
    n_bad       = 0;
    stall_seen  = 0;
`ifdef MEM_TIMEOUT_EN
    e_err_g     = 1'b0;
`endif
    for (int i = 0; i < 8; i++) mem_model[i] = 16'($urandom);
    rst         = 1'b1;
    stall       = '0;
    wData_i     = '0;
    wReg_i      = 1'b0;
    wRegAddr_i  = '0;
    memOp_i     = OP_NONE;
    memAddr_i   = '0;
    memData_i   = '0;
    bus_rdata_i = '0;
    bus_ack_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Out of reset: idle pass-through, quiet bus
    wData_i    = 16'h5A5A;
    wReg_i     = 1'b1;
    wRegAddr_i = 4'd9;
    chk_cycle("reset", 1'b0, 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0, 16'h0);

    // ALU result forwarding, including the reserved op encoding
    run_alu(OP_NONE, 16'h1234, 1'b1, 4'd3);
    run_alu(OP_RSVD, 16'hC0DE, 1'b0, 4'd6);

    // Load with ack in the third REQ cycle
    mem_model[0] = 16'hBEEF;
    run_mem(OP_LOAD, 16'h8000, 16'h1111, 16'h2222, 1'b1, 4'd5, 2, 0);

    // Store with immediate ack, one held DONE cycle
    run_mem(OP_STORE, 16'h4000, 16'h00AA, 16'h3333, 1'b1, 4'd2, 0, 1);

    // Back-to-back loads, the second reading the stored value back
    run_mem(OP_LOAD, 16'h8001, 16'h0000, 16'h4444, 1'b1, 4'd1, 1, 0);
    run_mem(OP_LOAD, 16'h8000, 16'h0000, 16'h5555, 1'b1, 4'd4, 0, 0);

    // Reset asserted in the second REQ cycle abandons the request
    memOp_i     = OP_LOAD;
    memAddr_i   = 16'h8003;
    memData_i   = 16'h5555;
    wData_i     = 16'h6666;
    wReg_i      = 1'b1;
    wRegAddr_i  = 4'd7;
    stall       = '0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 16'h0;
    chk_cycle("rst_idle", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk_cycle("rst_req1", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h8003, 16'h5555);
    rst = 1'b1;
    chk_cycle("rst_req2", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h8003, 16'h5555);
    rst     = 1'b0;
    memOp_i = OP_NONE;
    chk_cycle("rst_after", 1'b0, 1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, 16'h0, 16'h0);
    run_mem(OP_STORE, 16'h8005, 16'h7777, 16'h8888, 1'b0, 4'd8, 1, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack at all: abort after the REQ limit with error data
    memOp_i     = OP_LOAD;
    memAddr_i   = 16'h8004;
    memData_i   = 16'h0101;
    wData_i     = 16'h0202;
    wReg_i      = 1'b1;
    wRegAddr_i  = 4'd10;
    stall       = '0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 16'h1357;
    chk_cycle("to_idle", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int r = 0; r < 15; r++) begin
      chk_cycle("to_req", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h8004, 16'h0101);
    end
    e_err_g = 1'b1;
    chk_cycle("to_done", 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0);
    e_err_g = 1'b0;
    run_alu(OP_NONE, 16'h0F0F, 1'b1, 4'd1);
    // Ack on the last allowed REQ cycle wins over the timeout
    run_mem(OP_LOAD, 16'h8006, 16'h0000, 16'h0303, 1'b1, 4'd11, 14, 0);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == OP_LOAD || op == OP_STORE) begin
        run_mem(op, 16'h8000 | 16'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                1'($urandom), 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 2));
      end else begin
        run_alu(op, 16'($urandom), 1'($urandom), 4'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage of the 16-bit THCO-MIPS core. Sits between the EX/MEM register and mem_wb.
- Forwards ALU results unchanged for non-memory instructions.
- For LW/SW it runs a request/acknowledge transaction on the shared SRAM bus. It asserts a stall request until the data is available, then presents the write-back triple to mem_wb.

Parameters:
- DATA_W, 16, register/bus data width
- ADDR_W, 16, memory address width
- REG_ADDR_W, 4, register-file address width
- TIMEOUT, 15, maximum REQ cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- stall  in  6  pipeline stall vector; bit 4 = MEM stage hold
- wData_i  in  DATA_W  ALU result from EX/MEM
- wReg_i  in  1  register write enable from EX/MEM
- wRegAddr_i  in  REG_ADDR_W  destination register
- memOp_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- memAddr_i  in  ADDR_W  access address
- memData_i  in  DATA_W  store data
- wData_o  out  DATA_W  to mem_wb
- wReg_o  out  1  to mem_wb
- wRegAddr_o  out  REG_ADDR_W  to mem_wb
- stallreq_o  out  1  MEM stall request to the controller
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data, valid with ack
- bus_ack_i  in  1  one-cycle completion strobe
- mem_err_o  out  1  timeout flag (only present with MEM_TIMEOUT_EN)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high (RstEnable=1).
- Reset state:
  - state=IDLE.
  - Latched address, data, write-enable and load data all cleared to 0.
  - Counter cleared to 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - memOp none/reserved: outputs equal inputs combinationally; stallreq_o=0.
  - memOp load/store: stallreq_o=1 and wReg_o forced 0.
  - At the edge, latch memAddr_i, memData_i and we (store=1), then go to REQ.
- REQ:
  - bus_req_o=1; bus_addr_o, bus_wdata_o and bus_we_o are driven from the latches and stay stable for the whole request.
  - stallreq_o=1 and wReg_o=0.
  - On bus_ack_i=1: capture bus_rdata_i (loads only), then go to DONE.
  - Without ack: stay in REQ.
- DONE:
  - stallreq_o=0 and bus_req_o=0.
  - Load: wData_o = captured data.
  - Store: wData_o = wData_i.
  - wReg_o = wReg_i and wRegAddr_o = wRegAddr_i.
  - Go to IDLE when stall[4]=NoStop. Otherwise hold DONE and keep the outputs.
- Outside REQ: bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0.
- Latency: a load with ack in the first REQ cycle gives 2 stall cycles (IDLE, REQ); the data reaches mem_wb at the end of the DONE cycle.
- Boundary cases:
  - An ack arriving outside REQ is ignored.
  - Back-to-back memory ops: DONE always returns to IDLE, so the next op is detected in IDLE. There is no REQ→REQ chaining.
  - Reset mid-REQ: IDLE at the next edge and bus_req_o drops. The bus side must tolerate the abandoned request.
  - stall[4]=Stop while in IDLE with memOp≠none: the FSM still advances. The inputs are held by the upstream stall.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit counter increments each REQ cycle without ack and clears on entering REQ.
  - When the count reaches TIMEOUT, go to DONE with load data 0xFFFF.
  - mem_err_o pulses 1 for that DONE cycle.
  - An ack arriving in the same cycle as the limit wins over the timeout.
- Undefined: no counter and no mem_err_o port; REQ waits indefinitely.

Decomposition:
- The shared defines include gets:
  - MemOpBus (2-bit)
  - MemOpNone/Load/Store encodings
  - state encodings MemIdle/MemReq/MemDone
  - MemErrData (16'hFFFF)
- Existing RegBus, RegAddrBus, StallRegBus, RstEnable, Stop/NoStop and ZeroWord are reused.
- One natural sub-module: mem_bus_fsm (state, latches, counter). mem_access wraps it with the output mux.

Test Plan:
- ALU op, wData_i=16'h1234, wReg_i=1, addr 3 -> same cycle wData_o=1234, wReg_o=1, stallreq_o=0, bus_req_o=0.
- Load from 16'h8000, ack after 3 REQ cycles with rdata=16'hBEEF:
  - stallreq_o high for 4 cycles;
  - bus_addr_o stable at 8000 with bus_we_o=0;
  - DONE wData_o=BEEF, wReg_o=1.
- Store 16'h00AA to 16'h4000, immediate ack -> bus_we_o=1, bus_wdata_o=00AA, exactly 2 stall cycles.
- Load then a second load next instruction -> two separate REQ phases with an IDLE between; no stray bus_req_o between them.
- rst=1 in the second REQ cycle -> next edge state IDLE, bus_req_o=0, stallreq_o=0 once memOp_i=none.
- MEM_TIMEOUT_EN, no ack -> DONE after 15 REQ cycles, wData_o=FFFF, mem_err_o=1 for one cycle.
